mtsp_thread_scheduler: RTL and testbench

//  Round-robin issue scheduler for the per-thread status array in the MTSP core.

---
 rtl/mtsp_sched_pkg.sv | 32 +++
 rtl/mtsp_rr_arbiter.sv | 22 ++
 rtl/mtsp_thread_scheduler.sv | 106 ++++++++++
 tb/tb_mtsp_thread_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mtsp_sched_pkg.sv
// Shared types and round-robin pick helper for the MTSP thread scheduler and memory port arbiter.
package mtsp_sched_pkg;

  localparam int THREAD_COUNT_DEF = 8;
  localparam int SIZE_PC          = 16;

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_OFFER} sched_state_t;

  // Rotate req so ptr sits at bit 0, priority-encode, then unrotate; mask = width-1.
  // Returns {found, tid}.
  function automatic logic [5:0] rr_pick(input logic [31:0] req,
                                         input logic [4:0]  ptr,
                                         input logic [4:0]  mask);
    logic [31:0] rot;
    logic        found;
    logic [4:0]  off;
    rot   = '0;
    found = 1'b0;
    off   = '0;
    for (int i = 0; i < 32; i++) begin
      rot[i] = req[(5'(i) + ptr) & mask];
    end
    for (int i = 31; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = 5'(i);
      end
    end
    return {found, (off + ptr) & mask};
  endfunction

endpackage

// File: rtl/mtsp_rr_arbiter.sv
// Round-robin arbiter: first set req bit at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; grant follows req/ptr every cycle.
module mtsp_rr_arbiter
  import mtsp_sched_pkg::*;
#(
  parameter int N  = 8,
  localparam int TW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [TW-1:0] ptr,
  output logic          grant_valid,
  output logic [TW-1:0] grant_tid
);

  logic [5:0] pick;

  assign pick        = rr_pick(32'(req), 5'(ptr), 5'(N - 1));
  assign grant_valid = pick[5];
  assign grant_tid   = TW'(pick);

endmodule

// File: rtl/mtsp_thread_scheduler.sv
// Round-robin issue scheduler: offers one runnable thread's PC per ARB/OFFER pair.
// Latency: RUN in idle -> ISSUE_VALID two cycles later; at most one issue per two cycles.
// Backpressure: slot held stable while ISSUE_READY is low; withdrawn if its thread stops running.
module mtsp_thread_scheduler
  import mtsp_sched_pkg::*;
#(
  parameter int  THREAD_COUNT = THREAD_COUNT_DEF,
  parameter int  PC_W         = SIZE_PC,
  localparam int TID_W        = $clog2(THREAD_COUNT)
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [THREAD_COUNT-1:0]      TRD_BUSY,
  input  logic [THREAD_COUNT-1:0]      TRD_RUN,
  input  logic [THREAD_COUNT*PC_W-1:0] TRD_PC,
  output logic                         ISSUE_VALID,
  input  logic                         ISSUE_READY,
  output logic [TID_W-1:0]             ISSUE_TID,
  output logic [PC_W-1:0]              ISSUE_PC,
  input  logic                         CMD_EN,
  output logic [THREAD_COUNT-1:0]      TRD_nEN,
  input  logic                         WAKE_EN,
  input  logic [TID_W-1:0]             WAKE_TID,
  output logic [THREAD_COUNT-1:0]      TRD_nAWAKE,
  output logic                         nSOLITUDE,
  output logic                         IDLE
);

  sched_state_t     state, state_nxt;
  logic [TID_W-1:0] rr_ptr;
  logic [TID_W-1:0] last_tid;
  logic             grant_valid;
  logic [TID_W-1:0] grant_tid;
  logic             load_slot;
  logic             handshake;

  mtsp_rr_arbiter #(.N(THREAD_COUNT)) u_arb (
    .req         (TRD_RUN),
    .ptr         (rr_ptr),
    .grant_valid (grant_valid),
    .grant_tid   (grant_tid)
  );

  always_comb begin
    state_nxt = state;
    load_slot = 1'b0;
    handshake = 1'b0;
    unique case (state)
      S_IDLE: if (|TRD_RUN) state_nxt = S_ARB;
      S_ARB: begin
        if (grant_valid) begin
          load_slot = 1'b1;
          state_nxt = S_OFFER;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_OFFER: begin
        // A handshake completes even if the thread's RUN drops in the same cycle.
        if (ISSUE_READY) begin
          handshake = 1'b1;
          state_nxt = (|TRD_RUN) ? S_ARB : S_IDLE;
        end else if (!TRD_RUN[ISSUE_TID]) begin
          state_nxt = S_ARB;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign ISSUE_VALID = (state == S_OFFER);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      last_tid   <= '0;
      ISSUE_TID  <= '0;
      ISSUE_PC   <= '0;
      TRD_nAWAKE <= '1;
      nSOLITUDE  <= 1'b1;
      IDLE       <= 1'b1;
    end else begin
      state <= state_nxt;
      if (load_slot) begin
        ISSUE_TID <= grant_tid;
        ISSUE_PC  <= TRD_PC[grant_tid*PC_W +: PC_W];
      end
      if (handshake) begin
        last_tid <= ISSUE_TID;
        rr_ptr   <= ISSUE_TID + TID_W'(1);
      end
      TRD_nAWAKE <= '1;
      if (WAKE_EN) TRD_nAWAKE[WAKE_TID] <= 1'b0;
      nSOLITUDE <= ($countones(TRD_BUSY) != 1);
      IDLE      <= (TRD_BUSY == '0) && (state == S_IDLE);
    end
  end

  // Commands from decode target the last accepted thread, not the one being offered.
  always_comb begin
    TRD_nEN           = '1;
    TRD_nEN[last_tid] = ~CMD_EN;
  end

endmodule

// File: tb/tb_mtsp_thread_scheduler.sv
// Directed plus randomized bench for mtsp_thread_scheduler with a queue-free issue-order model.
module tb_mtsp_thread_scheduler;

  localparam int N  = 8;
  localparam int PW = 16;

  logic          CLK = 1'b0;
  logic          nRST;
  logic [N-1:0]  TRD_BUSY;
  logic [N-1:0]  TRD_RUN;
  logic [N*PW-1:0] TRD_PC;
  logic          ISSUE_VALID;
  logic          ISSUE_READY;
  logic [2:0]    ISSUE_TID;
  logic [PW-1:0] ISSUE_PC;
  logic          CMD_EN;
  logic [N-1:0]  TRD_nEN;
  logic          WAKE_EN;
  logic [2:0]    WAKE_TID;
  logic [N-1:0]  TRD_nAWAKE;
  logic          nSOLITUDE;
  logic          IDLE;

  logic [PW-1:0] pc_tab [N];

  int checks = 0;
  int errors = 0;

  int          cyc = 0;
  int          last_hs = -10;
  int          model_rr;
  int          model_last;
  int          exp_tid;
  int          need;
  int          got;
  int          budget;
  bit          done;
  logic [7:0]  prev_busy = 8'h00;
  logic        prev_wake_en = 1'b0;
  logic [2:0]  prev_wake_tid = 3'd0;
  logic [7:0]  exp8;
  logic [PW-1:0] pc7_held;

  always #5 CLK = ~CLK;

  always_comb begin
    for (int i = 0; i < N; i++) TRD_PC[i*PW +: PW] = pc_tab[i];
  end

  mtsp_thread_scheduler #(.THREAD_COUNT(N), .PC_W(PW)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .TRD_BUSY    (TRD_BUSY),
    .TRD_RUN     (TRD_RUN),
    .TRD_PC      (TRD_PC),
    .ISSUE_VALID (ISSUE_VALID),
    .ISSUE_READY (ISSUE_READY),
    .ISSUE_TID   (ISSUE_TID),
    .ISSUE_PC    (ISSUE_PC),
    .CMD_EN      (CMD_EN),
    .TRD_nEN     (TRD_nEN),
    .WAKE_EN     (WAKE_EN),
    .WAKE_TID    (WAKE_TID),
    .TRD_nAWAKE  (TRD_nAWAKE),
    .nSOLITUDE   (nSOLITUDE),
    .IDLE        (IDLE)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First runnable thread at or above rr, wrapping around the thread ring.
  function automatic int model_pick(input logic [7:0] run, input int rr);
    for (int i = 0; i < N; i++) begin
      if (run[(rr + i) % N]) return (rr + i) % N;
    end
    return -1;
  endfunction

  // One clock with solitude/wake checks against the previous cycle's inputs, then new random ones.
  task automatic rand_edge();
    logic [7:0] aw;
    @(negedge CLK);
    cyc++;
    chk("solitude", 32'(nSOLITUDE), 32'($countones(prev_busy) != 1));
    aw = 8'hFF;
    if (prev_wake_en) aw[prev_wake_tid] = 1'b0;
    chk("awake", 32'(TRD_nAWAKE), 32'(aw));
    TRD_BUSY = 8'($urandom_range(0, 255));
    if ($urandom_range(0, 3) == 0) TRD_BUSY = 8'h01 << $urandom_range(0, 7);
    WAKE_EN  = 1'($urandom_range(0, 1));
    WAKE_TID = 3'($urandom_range(0, 7));
    prev_busy     = TRD_BUSY;
    prev_wake_en  = WAKE_EN;
    prev_wake_tid = WAKE_TID;
  endtask

  initial begin
    nRST = 1'b0; TRD_RUN = 8'hFF; TRD_BUSY = 8'h00; ISSUE_READY = 1'b0;
    CMD_EN = 1'b0; WAKE_EN = 1'b0; WAKE_TID = 3'd0;
    for (int i = 0; i < N; i++) pc_tab[i] = 16'h1000 + 16'(i * 17);

    // Reset held with every thread runnable.
    repeat (3) @(negedge CLK);
    chk("rst_valid",  32'(ISSUE_VALID), 32'(0));
    chk("rst_tid",    32'(ISSUE_TID),   32'(0));
    chk("rst_pc",     32'(ISSUE_PC),    32'(0));
    chk("rst_nen",    32'(TRD_nEN),     32'hFF);
    chk("rst_nawake", 32'(TRD_nAWAKE),  32'hFF);
    chk("rst_nsol",   32'(nSOLITUDE),   32'(1));
    chk("rst_idle",   32'(IDLE),        32'(1));

    // Fairness: 0..7 then 0, one issue every two cycles.
    nRST = 1'b1; ISSUE_READY = 1'b1;
    @(negedge CLK);
    chk("latency_arb", 32'(ISSUE_VALID), 32'(0));
    @(negedge CLK);
    chk("first_valid", 32'(ISSUE_VALID), 32'(1));
    chk("first_tid",   32'(ISSUE_TID),   32'(0));
    chk("first_pc",    32'(ISSUE_PC),    32'(pc_tab[0]));
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      chk("fair_gap", 32'(ISSUE_VALID), 32'(0));
      @(negedge CLK);
      chk("fair_valid", 32'(ISSUE_VALID), 32'(1));
      chk("fair_tid",   32'(ISSUE_TID),   32'(k % N));
      chk("fair_pc",    32'(ISSUE_PC),    32'(pc_tab[k % N]));
    end

    // Backpressure and wrap: only threads 0 and 7 runnable, pointer at 1 after issuing 0.
    TRD_RUN = 8'b1000_0001;
    @(negedge CLK);
    ISSUE_READY = 1'b0;
    chk("bp_arb", 32'(ISSUE_VALID), 32'(0));
    pc7_held = pc_tab[7];
    for (int j = 0; j < 6; j++) begin
      @(negedge CLK);
      chk("bp_valid", 32'(ISSUE_VALID), 32'(1));
      chk("bp_tid",   32'(ISSUE_TID),   32'(7));
      chk("bp_pc",    32'(ISSUE_PC),    32'(pc7_held));
      if (j == 1) pc_tab[7] = 16'hBEEF;
      if (j == 5) ISSUE_READY = 1'b1;
    end
    @(negedge CLK);
    chk("wrap_gap", 32'(ISSUE_VALID), 32'(0));
    @(negedge CLK);
    chk("wrap_valid", 32'(ISSUE_VALID), 32'(1));
    chk("wrap_tid",   32'(ISSUE_TID),   32'(0));

    // Withdraw: thread 3 offered, its RUN drops, next offer is thread 5.
    TRD_RUN = 8'b0010_1000;
    @(negedge CLK);
    ISSUE_READY = 1'b0;
    @(negedge CLK);
    chk("wd_offer_tid", 32'(ISSUE_TID),   32'(3));
    chk("wd_offer_vld", 32'(ISSUE_VALID), 32'(1));
    TRD_RUN = 8'b0010_0000;
    @(negedge CLK);
    chk("wd_drop", 32'(ISSUE_VALID), 32'(0));
    @(negedge CLK);
    chk("wd_next_vld", 32'(ISSUE_VALID), 32'(1));
    chk("wd_next_tid", 32'(ISSUE_TID),   32'(5));

    // Steering: a command in the handshake cycle still targets the previous thread (0).
    ISSUE_READY = 1'b1; CMD_EN = 1'b1; TRD_RUN = 8'h00;
    #1 chk("nen_prev_last", 32'(TRD_nEN), 32'hFE);
    @(negedge CLK);
    ISSUE_READY = 1'b0;
    #1 chk("nen_tid5", 32'(TRD_nEN), 32'hDF);
    CMD_EN = 1'b0;
    #1 chk("nen_off", 32'(TRD_nEN), 32'hFF);

    // Wake pulse for thread 2, one cycle late and one cycle wide.
    WAKE_EN = 1'b1; WAKE_TID = 3'd2;
    #1 chk("wake_not_yet", 32'(TRD_nAWAKE), 32'hFF);
    @(negedge CLK);
    chk("wake_pulse", 32'(TRD_nAWAKE), 32'hFB);
    WAKE_EN = 1'b0;
    @(negedge CLK);
    chk("wake_end", 32'(TRD_nAWAKE), 32'hFF);
    chk("idle_high", 32'(IDLE),      32'(1));
    chk("sol_none",  32'(nSOLITUDE), 32'(1));

    // Solitude 00 -> 10 -> 30.
    TRD_BUSY = 8'h10;
    #1 chk("sol_lag", 32'(nSOLITUDE), 32'(1));
    @(negedge CLK);
    chk("sol_one",  32'(nSOLITUDE), 32'(0));
    chk("idle_low", 32'(IDLE),      32'(0));
    TRD_BUSY = 8'h30;
    @(negedge CLK);
    chk("sol_two", 32'(nSOLITUDE), 32'(1));
    TRD_BUSY = 8'h00;

    // Randomized segments: issue order, PC, pacing, steering, wake and solitude against the model.
    model_rr   = 6;
    model_last = 5;
    for (int seg = 0; seg < 40; seg++) begin
      rand_edge();
      chk("seg_start_idle", 32'(ISSUE_VALID), 32'(0));
      TRD_RUN = 8'($urandom_range(1, 255));
      for (int i = 0; i < N; i++) pc_tab[i] = 16'($urandom);
      need   = $urandom_range(1, 4);
      got    = 0;
      budget = 0;
      done   = 1'b0;
      while (!done && budget < 200) begin
        rand_edge();
        budget++;
        ISSUE_READY = ($urandom_range(0, 2) != 0);
        CMD_EN      = 1'($urandom_range(0, 1));
        #1;
        exp8 = 8'hFF;
        if (CMD_EN) exp8[model_last] = 1'b0;
        chk("rand_nen", 32'(TRD_nEN), 32'(exp8));
        if (ISSUE_VALID && ISSUE_READY) begin
          exp_tid = model_pick(TRD_RUN, model_rr);
          chk("rand_tid", 32'(ISSUE_TID), 32'(exp_tid));
          chk("rand_pc",  32'(ISSUE_PC),  32'(pc_tab[exp_tid]));
          chk("rand_pace", 32'(cyc - last_hs >= 2), 32'(1));
          last_hs    = cyc;
          model_last = exp_tid;
          model_rr   = (exp_tid + 1) % N;
          got++;
          if (got == need) begin
            done    = 1'b1;
            TRD_RUN = 8'h00;
          end
        end
      end
      chk("seg_timeout", 32'(done), 32'(1));
      if (!done) break;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
